// File: rtl/blake2b_msched.sv
// BLAKE2b message/chaining-value scheduler: DEPTH-slot block FIFO with a self-sequencing round/step walker.
// Optional MSCHED_EXT_INDEX_EN replaces the internal SIGMA table with per-lane indices from mindex_bus_i.
module blake2b_msched #(
    parameter int WORD_W = 64,
    parameter int ROUNDS = 12,
    parameter int DEPTH  = 2,
    parameter int SEL_N  = 8
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    in_valid,
    output logic                    in_ready,
    input  logic [16*WORD_W-1:0]    m_i,
    input  logic [8*WORD_W-1:0]     h_i,
`ifdef MSCHED_EXT_INDEX_EN
    input  logic [SEL_N*4-1:0]      mindex_bus_i,
`endif
    output logic                    step_valid,
    input  logic                    step_ready,
    output logic [SEL_N*WORD_W-1:0] m_bus_o,
    output logic [8*WORD_W-1:0]     h_o,
    output logic [3:0]              round_o,
    output logic [1:0]              step_o,
    output logic                    last_o,
    output logic                    blk_done
);
    localparam int SPR   = 16 / SEL_N;
    localparam int CNT_W = $clog2(DEPTH + 1);
    localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam logic [3:0] LAST_RND  = 4'(ROUNDS - 1);
    localparam logic [1:0] LAST_STEP = 2'(SPR - 1);

    typedef enum logic {IDLE, RUN} state_t;

    state_t              state_q;
    logic                step_valid_q;
    logic [CNT_W-1:0]    count_q, count_d;
    logic [PTR_W-1:0]    wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
    logic [3:0]          round_q, round_d;
    logic [1:0]          step_q, step_d;
    logic                last_q, last_d;
    logic                blk_done_q;
    logic [SEL_N*WORD_W-1:0] m_bus_q, bus_d;
    logic [8*WORD_W-1:0] h_q;

    logic [16*WORD_W-1:0] slot_m_q [DEPTH];
    logic [8*WORD_W-1:0]  slot_h_q [DEPTH];
    logic [16*WORD_W-1:0] head_m;
    logic [8*WORD_W-1:0]  head_h;

    logic load, accept, is_last, pop, upd;

`ifndef MSCHED_EXT_INDEX_EN
    // Row r holds SIGMA[r][0] in the least significant nibble.
    function automatic logic [3:0] sigma(input logic [3:0] rnd, input logic [3:0] pos);
        logic [63:0] row;
        logic [3:0]  r;
        r = (rnd >= 4'd10) ? rnd - 4'd10 : rnd;
        case (r)
            4'd0:    row = 64'hFEDCBA9876543210;
            4'd1:    row = 64'h357B20C16DF984AE;
            4'd2:    row = 64'h491763EADF250C8B;
            4'd3:    row = 64'h8F04A562EBCD1397;
            4'd4:    row = 64'hD386CB1EFA427509;
            4'd5:    row = 64'h91EF57D438B0A6C2;
            4'd6:    row = 64'hB8293670A4DEF15C;
            4'd7:    row = 64'hA2684F05931CE7BD;
            4'd8:    row = 64'h5A417D2C803B9EF6;
            4'd9:    row = 64'h0DC39EBF5167482A;
            default: row = 64'hFEDCBA9876543210;
        endcase
        return row[pos*4 +: 4];
    endfunction
`endif

    function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] p);
        return (p == PTR_W'(DEPTH - 1)) ? '0 : p + 1'b1;
    endfunction

    assign in_ready = (count_q < CNT_W'(DEPTH));
    assign load     = in_valid && in_ready;
    assign accept   = step_valid_q && step_ready;
    assign is_last  = (round_q == LAST_RND) && (step_q == LAST_STEP);
    assign pop      = accept && is_last;
    assign wr_ptr_d = load ? ptr_inc(wr_ptr_q) : wr_ptr_q;
    assign rd_ptr_d = pop  ? ptr_inc(rd_ptr_q) : rd_ptr_q;

    always_comb begin
        count_d = count_q;
        case ({load, pop})
            2'b10:   count_d = count_q + 1'b1;
            2'b01:   count_d = count_q - 1'b1;
            default: count_d = count_q;
        endcase
    end

    always_comb begin
        round_d = round_q;
        step_d  = step_q;
        if (accept) begin
            if (is_last) begin
                round_d = '0;
                step_d  = '0;
            end else if (step_q == LAST_STEP) begin
                round_d = round_q + 4'd1;
                step_d  = '0;
            end else begin
                step_d = step_q + 2'd1;
            end
        end
        last_d = (round_d == LAST_RND) && (step_d == LAST_STEP);
    end

    // The next head slot may be the one being written this edge (empty buffer, or pop of the sole block).
    always_comb begin
        if (load && (wr_ptr_q == rd_ptr_d)) begin
            head_m = m_i;
            head_h = h_i;
        end else begin
            head_m = slot_m_q[rd_ptr_d];
            head_h = slot_h_q[rd_ptr_d];
        end
    end

    always_comb begin
        logic [3:0] idx;
        bus_d = '0;
        idx   = '0;
        for (int k = 0; k < SEL_N; k++) begin
`ifdef MSCHED_EXT_INDEX_EN
            idx = mindex_bus_i[k*4 +: 4];
`else
            idx = sigma(round_d, 4'(int'(step_d) * SEL_N + k));
`endif
            bus_d[k*WORD_W +: WORD_W] = head_m[idx*WORD_W +: WORD_W];
        end
    end

    assign upd = (count_d != '0) && !(step_valid_q && !step_ready);

    always_ff @(posedge clk) begin
        if (load) begin
            slot_m_q[wr_ptr_q] <= m_i;
            slot_h_q[wr_ptr_q] <= h_i;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q      <= IDLE;
            step_valid_q <= 1'b0;
            count_q      <= '0;
            wr_ptr_q     <= '0;
            rd_ptr_q     <= '0;
            round_q      <= '0;
            step_q       <= '0;
            last_q       <= 1'b0;
            blk_done_q   <= 1'b0;
            m_bus_q      <= '0;
            h_q          <= '0;
        end else begin
            count_q    <= count_d;
            wr_ptr_q   <= wr_ptr_d;
            rd_ptr_q   <= rd_ptr_d;
            round_q    <= round_d;
            step_q     <= step_d;
            last_q     <= last_d;
            blk_done_q <= pop;
            if (upd) begin
                m_bus_q <= bus_d;
                h_q     <= head_h;
            end
            case (state_q)
                IDLE: if (count_d != '0) begin
                    state_q      <= RUN;
                    step_valid_q <= 1'b1;
                end
                RUN: if (count_d == '0) begin
                    state_q      <= IDLE;
                    step_valid_q <= 1'b0;
                end
                default: begin
                    state_q      <= IDLE;
                    step_valid_q <= 1'b0;
                end
            endcase
        end
    end

    assign step_valid = step_valid_q;
    assign m_bus_o    = m_bus_q;
    assign h_o        = h_q;
    assign round_o    = round_q;
    assign step_o     = step_q;
    assign last_o     = last_q;
    assign blk_done   = blk_done_q;
endmodule

// File: tb/tb_blake2b_msched.sv
// Scoreboard bench for blake2b_msched: default instance (SEL_N=8) plus a SEL_N=4 instance.
module tb_blake2b_msched;
    logic clk, rst;
    logic in_valid, in_ready, step_valid, step_ready, last_o, blk_done;
    logic [1023:0] m_i;
    logic [511:0]  h_i, h_o, m_bus_o;
    logic [3:0]    round_o;
    logic [1:0]    step_o;

    logic in_valid4, in_ready4, step_valid4, step_ready4, last4, done4;
    logic [1023:0] m4;
    logic [511:0]  h4, h4_o;
    logic [255:0]  bus4;
    logic [3:0]    round4;
    logic [1:0]    step4;

    blake2b_msched dut (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready), .m_i(m_i), .h_i(h_i),
        .step_valid(step_valid), .step_ready(step_ready), .m_bus_o(m_bus_o), .h_o(h_o),
        .round_o(round_o), .step_o(step_o), .last_o(last_o), .blk_done(blk_done));

    blake2b_msched #(.SEL_N(4)) dut4 (
        .clk(clk), .rst(rst), .in_valid(in_valid4), .in_ready(in_ready4), .m_i(m4), .h_i(h4),
        .step_valid(step_valid4), .step_ready(step_ready4), .m_bus_o(bus4), .h_o(h4_o),
        .round_o(round4), .step_o(step4), .last_o(last4), .blk_done(done4));

    typedef struct {
        logic [511:0] bus;
        logic [3:0]   rnd;
        logic [1:0]   stp;
        logic         last;
        logic [511:0] h;
    } exp_t;

    exp_t q[$];
    exp_t q4[$];
    int checks = 0;
    int errors = 0;
    int acc = 0, acc4 = 0, dones = 0;

    int SIG [10][16] = '{
        '{ 0,  1,  2,  3,  4,  5,  6,  7,  8,  9, 10, 11, 12, 13, 14, 15},
        '{14, 10,  4,  8,  9, 15, 13,  6,  1, 12,  0,  2, 11,  7,  5,  3},
        '{11,  8, 12,  0,  5,  2, 15, 13, 10, 14,  3,  6,  7,  1,  9,  4},
        '{ 7,  9,  3,  1, 13, 12, 11, 14,  2,  6,  5, 10,  4,  0, 15,  8},
        '{ 9,  0,  5,  7,  2,  4, 10, 15, 14,  1, 11, 12,  6,  8,  3, 13},
        '{ 2, 12,  6, 10,  0, 11,  8,  3,  4, 13,  7,  5, 15, 14,  1,  9},
        '{12,  5,  1, 15, 14, 13,  4, 10,  0,  7,  6,  3,  9,  2,  8, 11},
        '{13, 11,  7, 14, 12,  1,  3,  9,  5,  0, 15,  4,  8,  6,  2, 10},
        '{ 6, 15, 14,  9, 11,  3,  0,  8, 12,  2, 13,  7,  1,  4, 10,  5},
        '{10,  2,  8,  4,  7,  6,  1,  5, 15, 11, 14,  9,  3, 12, 13,  0}
    };

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [511:0] obs, input logic [511:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    function automatic logic [1023:0] mk_seq(input int base);
        logic [1023:0] v;
        for (int i = 0; i < 16; i++) v[i*64 +: 64] = 64'(base + i);
        return v;
    endfunction

    function automatic logic [1023:0] mk_rand();
        logic [1023:0] v;
        for (int i = 0; i < 16; i++) v[i*64 +: 64] = {$urandom, $urandom};
        return v;
    endfunction

    task automatic push_blk(input logic [1023:0] mv, input logic [511:0] hv, input int sel);
        exp_t e;
        int spr;
        spr = 16 / sel;
        for (int r = 0; r < 12; r++) begin
            for (int s = 0; s < spr; s++) begin
                e.bus = '0;
                for (int k = 0; k < sel; k++)
                    e.bus[k*64 +: 64] = mv[SIG[r % 10][s*sel + k]*64 +: 64];
                e.rnd  = 4'(r);
                e.stp  = 2'(s);
                e.last = (r == 11) && (s == spr - 1);
                e.h    = hv;
                if (sel == 8) q.push_back(e);
                else          q4.push_back(e);
            end
        end
    endtask

    // Sample before the edge to see which steps are accepted, then check blk_done after it.
    task automatic tick();
        exp_t e;
        logic exp_done;
        exp_done = 1'b0;
        @(negedge clk);
        if (step_valid && step_ready) begin
            if (q.size() == 0) begin
                chk("unexpected_step", 512'(q.size()), 512'd1);
            end else begin
                e = q.pop_front();
                chk("m_bus", m_bus_o, e.bus);
                chk("round", 512'(round_o), 512'(e.rnd));
                chk("step", 512'(step_o), 512'(e.stp));
                chk("last", 512'(last_o), 512'(e.last));
                chk("h_o", h_o, e.h);
                exp_done = e.last;
                acc++;
            end
        end
        if (step_valid4 && step_ready4) begin
            if (q4.size() == 0) begin
                chk("unexpected_step4", 512'(q4.size()), 512'd1);
            end else begin
                e = q4.pop_front();
                chk("m_bus4", 512'(bus4), e.bus);
                chk("round4", 512'(round4), 512'(e.rnd));
                chk("step4", 512'(step4), 512'(e.stp));
                chk("last4", 512'(last4), 512'(e.last));
                acc4++;
            end
        end
        @(posedge clk);
        #1;
        chk("blk_done", 512'(blk_done), 512'(exp_done));
        if (blk_done) dones++;
    endtask

    task automatic drain(input string tag, input bit no_bubble);
        for (int n = 0; n < 200 && q.size() > 0; n++) begin
            if (no_bubble) chk({tag, "_valid"}, 512'(step_valid), 512'd1);
            tick();
        end
        chk({tag, "_drained"}, 512'(q.size()), 512'd0);
    endtask

    initial begin
        logic [1023:0] blk_a, blk_b, blk_c, blk_f;
        int acc0, done0;
        rst = 1'b0;
        in_valid = 1'b0; step_ready = 1'b0; m_i = '0; h_i = '0;
        in_valid4 = 1'b0; step_ready4 = 1'b0; m4 = '0; h4 = '0;
        tick(); tick();
        chk("rst_in_ready", 512'(in_ready), 512'd1);
        chk("rst_step_valid", 512'(step_valid), 512'd0);
        chk("rst_m_bus", m_bus_o, 512'd0);
        chk("rst_h_o", h_o, 512'd0);
        chk("rst_round", 512'(round_o), 512'd0);
        chk("rst_step", 512'(step_o), 512'd0);
        chk("rst_last", 512'(last_o), 512'd0);
        rst = 1'b1;
        tick();

        // Single block with M[i] = 0x100+i; also covers rounds 10 and 11 via the table model.
        m_i = mk_seq(32'h100);
        h_i = {8{64'h0A00_0000_0000_00AA}};
        in_valid = 1'b1;
        push_blk(m_i, h_i, 8);
        tick();
        in_valid = 1'b0;
        chk("load_latency", 512'(step_valid), 512'd1);
        chk("first_word", 512'(m_bus_o[63:0]), 512'h100);
        step_ready = 1'b1;
        done0 = dones;
        drain("single", 1'b1);
        tick();
        chk("single_done_count", 512'(dones - done0), 512'd1);
        chk("single_idle", 512'(step_valid), 512'd0);

        // Fill both slots under backpressure; a third request must be refused.
        step_ready = 1'b0;
        blk_a = mk_rand();
        blk_b = mk_rand();
        blk_c = mk_rand();
        m_i = blk_a; h_i = {16{$urandom}}; in_valid = 1'b1;
        push_blk(m_i, h_i, 8);
        tick();
        m_i = blk_b; h_i = {16{$urandom}};
        push_blk(m_i, h_i, 8);
        tick();
        chk("full_in_ready", 512'(in_ready), 512'd0);
        m_i = blk_c; h_i = '1;
        for (int i = 0; i < 3; i++) begin
            tick();
            chk("full_refuse", 512'(in_ready), 512'd0);
        end
        in_valid = 1'b0;
        for (int i = 0; i < 20; i++) begin
            chk("hold_bus", m_bus_o, q[0].bus);
            chk("hold_valid", 512'(step_valid), 512'd1);
            tick();
        end

        // Release: 48 back-to-back steps with no bubble and two blk_done pulses.
        acc0 = acc; done0 = dones;
        step_ready = 1'b1;
        drain("b2b", 1'b1);
        chk("b2b_steps", 512'(acc - acc0), 512'd48);
        chk("b2b_dones", 512'(dones - done0), 512'd2);
        tick();
        chk("b2b_idle", 512'(step_valid), 512'd0);

        // Mid-block asynchronous reset at round 5, then a clean restart.
        m_i = mk_rand(); h_i = {16{$urandom}}; in_valid = 1'b1;
        push_blk(m_i, h_i, 8);
        tick();
        in_valid = 1'b0;
        for (int n = 0; n < 100 && round_o != 4'd5; n++) tick();
        chk("reach_round5", 512'(round_o), 512'd5);
        rst = 1'b0;
        #1;
        chk("mid_rst_valid", 512'(step_valid), 512'd0);
        chk("mid_rst_bus", m_bus_o, 512'd0);
        chk("mid_rst_h", h_o, 512'd0);
        chk("mid_rst_round", 512'(round_o), 512'd0);
        chk("mid_rst_ready", 512'(in_ready), 512'd1);
        q.delete();
        tick();
        rst = 1'b1;
        tick();
        m_i = mk_rand(); h_i = {16{$urandom}}; in_valid = 1'b1;
        push_blk(m_i, h_i, 8);
        tick();
        in_valid = 1'b0;
        chk("restart_round", 512'(round_o), 512'd0);
        chk("restart_step", 512'(step_o), 512'd0);
        drain("restart", 1'b1);
        tick();

        // SEL_N=4: four steps per round, 48 steps per block.
        blk_f = mk_rand();
        m4 = blk_f; h4 = {16{$urandom}}; in_valid4 = 1'b1;
        push_blk(m4, h4, 4);
        tick();
        in_valid4 = 1'b0;
        step_ready4 = 1'b1;
        acc0 = acc4;
        tick(); tick();
        chk("sel4_r0s2_lane0", 512'(bus4[63:0]), 512'(blk_f[8*64 +: 64]));
        chk("sel4_r0s2_lane3", 512'(bus4[255:192]), 512'(blk_f[11*64 +: 64]));
        for (int n = 0; n < 200 && q4.size() > 0; n++) tick();
        chk("sel4_drained", 512'(q4.size()), 512'd0);
        chk("sel4_steps", 512'(acc4 - acc0), 512'd48);
        tick();
        chk("sel4_idle", 512'(step_valid4), 512'd0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
